// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Brief    : Shared types and helpers for the multi-channel memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam int DEFAULT_WORD_W = `WORD_SIZE;

    // Bits needed to hold 0..n-1, never less than one so vectors stay legal.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_rr_pick.sv
// ============================================================================
//  Module   : arb_rr_pick
//  Brief    : Combinational one-hot picker; search starts at i_ptr and wraps.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr_pick #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant
);

    int   ch;
    logic found;

    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        ch      = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            ch = (int'(i_ptr) + off) % NUM_CH;
            if (!found && i_req[ch]) begin
                o_grant[ch] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Merges NUM_CH cache line requesters onto one fixed-latency port.
//             ARB_ROUND_ROBIN_EN selects rotating priority (else lowest wins).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int WORD_W      = DEFAULT_WORD_W,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CH-1:0]                  ch_read,
    input  logic [NUM_CH-1:0]                  ch_write,
    input  logic [NUM_CH*WORD_W-1:0]           ch_addr,
    input  logic [NUM_CH*LINE_WORDS*WORD_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]                  ch_done,
    output logic [LINE_WORDS*WORD_W-1:0]       ch_rdata,
    output logic                               busy,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic [WORD_W-1:0]                  mem_addr,
    output logic [WORD_W-1:0]                  mem_wdata,
    input  logic [WORD_W-1:0]                  mem_rdata
);

    localparam int                 C_IDX_W    = idx_width(LINE_WORDS);
    localparam int                 C_CNT_W    = idx_width(MEM_LATENCY);
    localparam int                 C_PTR_W    = idx_width(NUM_CH);
    localparam int                 C_LINE_W   = LINE_WORDS * WORD_W;
    localparam logic [WORD_W-1:0]  C_IDX_MASK = WORD_W'(LINE_WORDS - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(LINE_WORDS - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(MEM_LATENCY - 1);

    arb_state_e                         state_q, state_d;
    logic [C_IDX_W-1:0]                 idx_q, idx_d;
    logic [C_CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_CH-1:0]                  winner_q, winner_d;
    logic                               is_write_q, is_write_d;
    logic [WORD_W-1:0]                  base_q, base_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  wdata_q, wdata_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  line_q, line_d;

    logic [NUM_CH-1:0]                  w_req;
    logic [NUM_CH-1:0]                  w_grant;
    logic [C_PTR_W-1:0]                 w_ptr;
    logic [WORD_W-1:0]                  w_sel_addr;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  w_sel_wdata;
    logic                               w_sel_write;
    logic                               w_access;

    assign w_req = ch_read | ch_write;

    arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (C_PTR_W)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_grant (w_grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [C_PTR_W-1:0] ptr_q, ptr_d;

    // Next search starts just after the channel that finished.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (winner_q[i]) ptr_d = C_PTR_W'((i + 1) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = '0;
`endif

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_addr  = ch_addr[i*WORD_W +: WORD_W];
                w_sel_wdata = ch_wdata[i*C_LINE_W +: C_LINE_W];
                w_sel_write = ch_write[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        winner_d   = winner_q;
        is_write_d = is_write_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        line_d     = line_q;
        case (state_q)
            IDLE: begin
                if (|w_req) begin
                    state_d    = ACCESS;
                    winner_d   = w_grant;
                    is_write_d = w_sel_write;
                    base_d     = w_sel_addr & ~C_IDX_MASK;
                    wdata_d    = w_sel_wdata;
                    idx_d      = '0;
                    cnt_d      = C_CNT_INIT;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - C_CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d = C_CNT_INIT;
                    if (!is_write_q) line_d[idx_q] = mem_rdata;
                    if (idx_q == C_LAST_IDX) state_d = DONE;
                    else                     idx_d   = idx_q + C_IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            winner_q   <= '0;
            is_write_q <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            winner_q   <= winner_d;
            is_write_q <= is_write_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            line_q     <= line_d;
        end
    end

    // Memory-side outputs are gated so IDLE/DONE present an all-zero port.
    assign w_access  = (state_q == ACCESS);
    assign mem_read  = w_access & ~is_write_q;
    assign mem_write = w_access &  is_write_q;
    assign mem_addr  = w_access ? (base_q | WORD_W'(idx_q)) : '0;
    assign mem_wdata = w_access ? wdata_q[idx_q] : '0;
    assign ch_done   = (state_q == DONE) ? winner_q : '0;
    assign ch_rdata  = line_q;
    assign busy      = (state_q != IDLE);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && state_q == IDLE)
            assert (!(|(w_grant & ch_read & ch_write)))
                else $warning("mem_port_arbiter: read and write both set on granted channel; write performed");
    end
`endif

endmodule

`default_nettype wire
